// File: rtl/uart_tx_sched_pkg.sv
// Shared types, defaults and helpers for the UART transmit scheduler.
package uart_tx_sched_pkg;

  localparam int unsigned N_REQ_DEF        = 4;
  localparam int unsigned FRAME_CYCLES_DEF = 4400;
  localparam int unsigned GAP_CYCLES_DEF   = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Pointer to the index after ptr, wrapping n-1 back to 0.
  function automatic logic [2:0] next_rr(input logic [2:0] ptr, input int unsigned n);
    return ((32'(ptr) + 32'd1) >= n) ? 3'd0 : ptr + 3'd1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted req scanning ptr, ptr+1, ... mod N.
module rr_arbiter
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic         any,
  output logic [2:0]   idx
);

  logic [3:0] pos;

  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr < N and k < N, so a single subtraction is enough for the modulo.
      pos = {1'b0, ptr} + 4'(k);
      if (pos >= 4'(N)) pos = pos - 4'(N);
      if (!any && (|(req & (N'(1) << pos)))) begin
        any = 1'b1;
        idx = pos[2:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one RS232 byte transmitter among N_REQ sources.
// Optional macro UART_TX_SCHED_PRIO0_EN gives requester 0 strict priority.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned N_REQ        = N_REQ_DEF,
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES   = GAP_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  output logic               busy,
  output logic [2:0]         grant_id
);

  localparam int unsigned LAST = FRAME_CYCLES + GAP_CYCLES - 1;
  localparam int unsigned CW   = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    counter_q, counter_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic             tx_start_q, tx_start_d;
  logic             busy_q, busy_d;
  logic [2:0]       grant_id_q, grant_id_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;

  logic [N_REQ-1:0] arb_req;
  logic             arb_any, prio0_hit, win_any;
  logic [2:0]       arb_idx, win_idx;
  logic [7:0]       win_data;

`ifdef UART_TX_SCHED_PRIO0_EN
  assign prio0_hit = req_valid[0];
  assign arb_req   = req_valid & ~N_REQ'(1);
`else
  assign prio0_hit = 1'b0;
  assign arb_req   = req_valid;
`endif

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (arb_req),
    .ptr (rr_ptr_q),
    .any (arb_any),
    .idx (arb_idx)
  );

  assign win_any = prio0_hit | arb_any;
  assign win_idx = prio0_hit ? 3'd0 : arb_idx;

  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (3'(k) == win_idx) win_data = req_data[8*k +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    tx_data_d   = tx_data_q;
    req_ready_d = '0;
    tx_start_d  = 1'b0;
    busy_d      = busy_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (win_any) begin
          tx_data_d   = win_data;
          req_ready_d = N_REQ'(1) << win_idx;
          tx_start_d  = 1'b1;
          grant_id_d  = win_idx;
          busy_d      = 1'b1;
          counter_d   = '0;
          rr_ptr_d    = prio0_hit ? rr_ptr_q : next_rr(win_idx, N_REQ);
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        counter_d = counter_q + CW'(1);
        if (counter_q == CW'(LAST)) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      counter_q   <= '0;
      tx_data_q   <= '0;
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      tx_data_q   <= tx_data_d;
      req_ready_q <= req_ready_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign req_ready = req_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched (N_REQ=4, FRAME=20, GAP=2).
module tb_uart_tx_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned FR = 20;
  localparam int unsigned GP = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_ready;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         busy;
  logic [2:0]   grant_id;

  int checks = 0;
  int errors = 0;

  uart_tx_sched #(.N_REQ(N), .FRAME_CYCLES(FR), .GAP_CYCLES(GP)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Advance until the next tx_start pulse, bounded; returns cycles waited.
  task automatic wait_launch(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_start && n < 60);
    check("launch_seen", 32'(tx_start), 32'd1);
  endtask

  logic [7:0] bytes [N];
  int exp3 [5];
  int exp6 [4];
  int n;

  initial begin
`ifdef UART_TX_SCHED_PRIO0_EN
    exp3 = '{0, 0, 0, 0, 0};
    exp6 = '{0, 0, 0, 0};
`else
    exp3 = '{0, 1, 2, 3, 0};
    exp6 = '{0, 2, 0, 2};
`endif

    // 1: reset and quiet idle
    rst = 1'b0;
    req_valid = '0;
    req_data = '0;
    repeat (3) tick();
    check("rst_outs", 32'({req_ready, tx_start, busy, grant_id, tx_data}), 32'd0);
    rst = 1'b1;
    for (int t = 0; t < 50; t++) begin
      tick();
      check("idle_quiet", 32'({req_ready, tx_start, busy, grant_id, tx_data}), 32'd0);
    end

    // 2: single byte from requester 2
    req_data[23:16] = 8'h55;
    req_valid = 4'b0100;
    tick();
    check("s2_ready", 32'(req_ready), 32'h4);
    check("s2_start", 32'(tx_start), 32'd1);
    check("s2_data", 32'(tx_data), 32'h55);
    check("s2_gid", 32'(grant_id), 32'd2);
    check("s2_busy", 32'(busy), 32'd1);
    req_valid = '0;
    for (int t = 1; t < 22; t++) begin
      tick();
      check("s2_busy_hold", 32'(busy), 32'd1);
      check("s2_data_hold", 32'(tx_data), 32'h55);
      check("s2_pulses_low", 32'({req_ready, tx_start}), 32'd0);
    end
    tick();
    check("s2_busy_fall", 32'(busy), 32'd0);

    // 3: all four valid, each advancing to a new byte after its ack
    do_reset();
    for (int i = 0; i < int'(N); i++) begin
      bytes[i] = 8'hA0 + 8'(i);
      req_data[8*i +: 8] = bytes[i];
    end
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_launch(n);
      check("s3_gid", 32'(grant_id), 32'(exp3[k]));
      check("s3_ready", 32'(req_ready), 32'(1) << exp3[k]);
      check("s3_data", 32'(tx_data), 32'(bytes[exp3[k]]));
      if (k > 0) check("s3_interval", 32'(n), 32'd23);
      bytes[exp3[k]] = bytes[exp3[k]] + 8'h11;
      req_data[8*exp3[k] +: 8] = bytes[exp3[k]];
    end
    req_valid = '0;
    repeat (25) tick();

    // 4: request from 1 arrives mid-frame of requester 3
    do_reset();
    req_data[31:24] = 8'h33;
    req_data[15:8] = 8'h11;
    req_valid = 4'b1000;
    tick();
    check("s4_gid3", 32'(grant_id), 32'd3);
    check("s4_start3", 32'(tx_start), 32'd1);
    req_valid = '0;
    for (int t = 1; t <= 22; t++) begin
      tick();
      check("s4_no_ack", 32'(req_ready), 32'd0);
      check("s4_busy", 32'(busy), (t == 22) ? 32'd0 : 32'd1);
      if (t == 4) req_valid = 4'b0010;
    end
    tick();
    check("s4_ready1", 32'(req_ready), 32'h2);
    check("s4_gid1", 32'(grant_id), 32'd1);
    check("s4_data1", 32'(tx_data), 32'h11);
    req_valid = '0;

    // 5: reset at WAIT counter=10
    repeat (10) tick();
    rst = 1'b0;
    #1;
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_data", 32'(tx_data), 32'd0);
    check("s5_gid", 32'(grant_id), 32'd0);
    check("s5_pulses", 32'({req_ready, tx_start}), 32'd0);
    tick();
    rst = 1'b1;
    req_data[15:8] = 8'h1A;
    req_data[31:24] = 8'h3C;
    req_valid = 4'b1010;
    tick();
    check("s5_gid_after", 32'(grant_id), 32'd1);
    check("s5_data_after", 32'(tx_data), 32'h1A);
    req_valid = '0;
    repeat (25) tick();

    // 6: requesters 0 and 2 continuously valid
    do_reset();
    req_data[7:0] = 8'h0F;
    req_data[23:16] = 8'h2F;
    req_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_launch(n);
      check("s6_gid", 32'(grant_id), 32'(exp6[k]));
    end
    req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
